// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Main controller for a multicycle RISC-V style datapath. It steps each
//   instruction through fetch, decode, execute, memory and writeback. It
//   waits on a memory ready handshake and can time that wait out. An
//   illegal opcode or a memory timeout sends it to a trap state that only
//   rst can leave.
//
// Ports
//   clk             in   system clock, rising edge
//   rst             in   asynchronous active-high reset
//   opCode          in   opcode field of the IR
//   mem_ready       in   memory completes the current request this cycle
//   PCWrite         out  unconditional PC load
//   PCWriteCond     out  PC load if the ALU zero flag is set
//   IRWrite         out  IR load
//   regFileWrite    out  register file write enable
//   regFileWriteSrc out  0 = ALU, 1 = memory, 2 = PC+4
//   ALUOverride     out  force the ALU to add
//   ALUSrcA         out  0 = PC, 1 = register
//   ALUSrcB         out  0 = register, 1 = immediate, 2 = constant 4
//   mem_req         out  memory request valid
//   mem_we          out  memory write (store)
//   mem_instr       out  request is an instruction fetch
//   trap            out  controller halted; sticky until rst
//   trap_cause      out  0 = none, 1 = illegal opcode, 2 = memory timeout
module multicycle_controller #(
    parameter int OPCODE_WIDTH    = 7,
    parameter int ALU_SRC_B_WIDTH = 2,
    parameter int MEM_TIMEOUT     = 15,
    parameter bit TIMEOUT_EN      = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [OPCODE_WIDTH-1:0]    opCode,
    input  logic                       mem_ready,
    output logic                       PCWrite,
    output logic                       PCWriteCond,
    output logic                       IRWrite,
    output logic                       regFileWrite,
    output logic [1:0]                 regFileWriteSrc,
    output logic                       ALUOverride,
    output logic                       ALUSrcA,
    output logic [ALU_SRC_B_WIDTH-1:0] ALUSrcB,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic                       mem_instr,
    output logic                       trap,
    output logic [1:0]                 trap_cause
);

    localparam logic [6:0] OP_ALU_REG = 7'b0110011;
    localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    localparam logic [8:0] TIMEOUT_LIMIT = 9'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_B, EXEC_J,
        MEM_RD, MEM_WR, WB_ALU, WB_MEM, TRAP
    } state_t;

    typedef struct packed {
        logic                       pc_write;
        logic                       pc_write_cond;
        logic                       reg_write;
        logic [1:0]                 reg_src;
        logic                       alu_override;
        logic                       alu_src_a;
        logic [ALU_SRC_B_WIDTH-1:0] alu_src_b;
        logic                       mem_req;
        logic                       mem_we;
        logic                       mem_instr;
        logic                       trap;
    } ctrl_t;

    // Moore output table. IRWrite and the fetch half of PCWrite are
    // not stored here because they are qualified by mem_ready.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_req      = 1'b1;
                c.mem_instr    = 1'b1;
                c.alu_override = 1'b1;
                c.alu_src_b    = ALU_SRC_B_WIDTH'(2);
            end
            EXEC_R: c.alu_src_a = 1'b1;
            EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALU_SRC_B_WIDTH'(1);
            end
            EXEC_B: begin
                c.alu_src_a     = 1'b1;
                c.pc_write_cond = 1'b1;
            end
            EXEC_J: begin
                c.reg_write    = 1'b1;
                c.reg_src      = 2'd2;
                c.pc_write     = 1'b1;
                c.alu_src_b    = ALU_SRC_B_WIDTH'(1);
                c.alu_override = 1'b1;
            end
            MEM_RD: c.mem_req = 1'b1;
            MEM_WR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
            end
            WB_ALU: c.reg_write = 1'b1;
            WB_MEM: begin
                c.reg_write = 1'b1;
                c.reg_src   = 2'd1;
            end
            TRAP:    c.trap = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    state_t     state;
    state_t     nxt_state;
    logic [1:0] cause_q;
    logic [1:0] nxt_cause;
    logic [7:0] wait_cnt;
    ctrl_t      ctrl_q;

    logic [6:0] op_low;
    logic       op_upper_zero;
    logic       timed_out;

    assign op_low = opCode[6:0];

    // Wider opcodes are legal only when the bits above the low 7 are zero.
    generate
        if (OPCODE_WIDTH > 7) begin : g_wide_op
            assign op_upper_zero = ~|opCode[OPCODE_WIDTH-1:7];
        end else begin : g_narrow_op
            assign op_upper_zero = 1'b1;
        end
    endgenerate

    // The timeout fires on the low cycle that would bring the counter to
    // MEM_TIMEOUT. If mem_ready is high on that same cycle, the request
    // completes and no trap is raised.
    assign timed_out = TIMEOUT_EN && !mem_ready &&
                       (({1'b0, wait_cnt} + 9'd1) >= TIMEOUT_LIMIT);

    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        nxt_state = state;
        nxt_cause = cause_q;
        case (state)
            IDLE: nxt_state = FETCH;
            FETCH: begin
                if (mem_ready) begin
                    nxt_state = DECODE;
                end else if (timed_out) begin
                    nxt_state = TRAP;
                    nxt_cause = CAUSE_TIMEOUT;
                end
            end
            DECODE: begin
                if (!op_upper_zero) begin
                    nxt_state = TRAP;
                    nxt_cause = CAUSE_ILLEGAL;
                end else begin
                    case (op_low)
                        OP_ALU_REG:                    nxt_state = EXEC_R;
                        OP_ALU_IMM, OP_LOAD, OP_STORE: nxt_state = EXEC_I;
                        OP_BRANCH:                     nxt_state = EXEC_B;
                        OP_JAL:                        nxt_state = EXEC_J;
                        default: begin
                            nxt_state = TRAP;
                            nxt_cause = CAUSE_ILLEGAL;
                        end
                    endcase
                end
            end
            EXEC_R: nxt_state = WB_ALU;
            EXEC_I: begin
                if (op_low == OP_LOAD)       nxt_state = MEM_RD;
                else if (op_low == OP_STORE) nxt_state = MEM_WR;
                else                         nxt_state = WB_ALU;
            end
            EXEC_B, EXEC_J, WB_ALU, WB_MEM: nxt_state = FETCH;
            MEM_RD: begin
                if (mem_ready) begin
                    nxt_state = WB_MEM;
                end else if (timed_out) begin
                    nxt_state = TRAP;
                    nxt_cause = CAUSE_TIMEOUT;
                end
            end
            MEM_WR: begin
                if (mem_ready) begin
                    nxt_state = FETCH;
                end else if (timed_out) begin
                    nxt_state = TRAP;
                    nxt_cause = CAUSE_TIMEOUT;
                end
            end
            TRAP:    nxt_state = TRAP;
            default: nxt_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so each output flop holds
    // the decode of the state being entered and cannot glitch on opCode.
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cause_q  <= CAUSE_NONE;
            wait_cnt <= '0;
            ctrl_q   <= '0;
        end else begin
            state   <= nxt_state;
            cause_q <= nxt_cause;
            ctrl_q  <= decode_ctrl(nxt_state);
            // Staying in a wait state means mem_ready was low, so count.
            // Any other move, including entering a wait state, clears.
            if ((state == FETCH || state == MEM_RD || state == MEM_WR) &&
                nxt_state == state) begin
                if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Fetch completes in the cycle that mem_ready is seen.
    assign IRWrite         = ctrl_q.mem_instr & mem_ready;
    assign PCWrite         = ctrl_q.pc_write | (ctrl_q.mem_instr & mem_ready);
    assign PCWriteCond     = ctrl_q.pc_write_cond;
    assign regFileWrite    = ctrl_q.reg_write;
    assign regFileWriteSrc = ctrl_q.reg_src;
    assign ALUOverride     = ctrl_q.alu_override;
    assign ALUSrcA         = ctrl_q.alu_src_a;
    assign ALUSrcB         = ctrl_q.alu_src_b;
    assign mem_req         = ctrl_q.mem_req;
    assign mem_we          = ctrl_q.mem_we;
    assign mem_instr       = ctrl_q.mem_instr;
    assign trap            = ctrl_q.trap;
    assign trap_cause      = cause_q;

endmodule
